// File: rtl/stepper_cmd_sequencer.sv
// Buffers move/dwell commands in a small FIFO and issues them one at a time to the Stepper driver.
// Define STEPPER_SEQ_FLUSH_EN to make op 11 an immediate queue flush instead of a queued no-op.
module stepper_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned START_WAIT  = 16,
    parameter int unsigned DWELL_SHIFT = 10
) (
    input  logic                   CLK100MHZ,
    input  logic                   CPU_RESETN,
    input  logic [31:0]            cmd_data,
    input  logic                   cmd_wr,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic [31:0]            step_data,
    output logic                   step_new,
    input  logic                   step_busy,
    output logic                   seq_busy,
    output logic                   err_ovf,
    output logic [20:0]            last_target
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 21 + DWELL_SHIFT;
    localparam int unsigned SW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_START, S_RUN, S_DWELL} state_t;
    typedef enum logic [1:0] {OP_ABS = 2'b00, OP_REL = 2'b01, OP_DWELL = 2'b10, OP_AUX = 2'b11} op_t;

    logic [22:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, flush, wr_req, push, pop_req;
    op_t           head_op;
    logic [20:0]   head_arg;
    state_t        state, state_n;
    logic [20:0]   target_q;
    logic [CW-1:0] dwell_cnt;
    logic [SW-1:0] wait_cnt;
    logic          unused_bits;

    assign unused_bits = ^cmd_data[29:21];
    assign head_op     = op_t'(mem[rd_ptr][22:21]);
    assign head_arg    = mem[rd_ptr][20:0];
    assign full        = (count == (AW+1)'(DEPTH));

`ifdef STEPPER_SEQ_FLUSH_EN
    assign flush = cmd_wr && (cmd_data[31:30] == 2'b11);
`else
    assign flush = 1'b0;
`endif

    assign wr_req    = cmd_wr && !flush;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign push      = wr_req && (!full || pop_req);
    assign cmd_full  = full;
    assign cmd_count = count;
    assign seq_busy  = (state != S_IDLE) || (count != '0);

    always_ff @(posedge CLK100MHZ) begin
        if (push)
            mem[wr_ptr] <= {cmd_data[31:30], cmd_data[20:0]};
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_req)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop_req)
                count <= count + 1'b1;
            else if (pop_req && !push)
                count <= count - 1'b1;
            if (wr_req && full && !pop_req)
                err_ovf <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        pop_req = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && !step_busy && !flush) begin
                    pop_req = 1'b1;
                    case (head_op)
                        OP_ABS, OP_REL: state_n = S_ISSUE;
                        OP_DWELL:       state_n = S_DWELL;
                        default:        state_n = S_IDLE;
                    endcase
                end
            end
            S_ISSUE: state_n = S_START;
            S_START: begin
                if (step_busy)
                    state_n = S_RUN;
                else if (wait_cnt == SW'(START_WAIT - 1))
                    state_n = S_IDLE;
            end
            S_RUN: begin
                if (!step_busy)
                    state_n = S_IDLE;
            end
            S_DWELL: begin
                if (flush || (dwell_cnt <= CW'(1)))
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state       <= S_IDLE;
            target_q    <= '0;
            dwell_cnt   <= '0;
            wait_cnt    <= '0;
            step_new    <= 1'b0;
            step_data   <= '0;
            last_target <= '0;
        end else begin
            state    <= state_n;
            step_new <= 1'b0;
            if (pop_req) begin
                target_q  <= (head_op == OP_ABS) ? head_arg : last_target + head_arg;
                dwell_cnt <= (head_arg == '0) ? CW'(1) : (CW'(head_arg) << DWELL_SHIFT);
            end
            if (state == S_DWELL)
                dwell_cnt <= dwell_cnt - 1'b1;
            if (state == S_ISSUE)
                wait_cnt <= '0;
            else if (state == S_START)
                wait_cnt <= wait_cnt + 1'b1;
            // Outputs are registered, so the pulse lands in the cycle after ISSUE.
            if (state == S_ISSUE) begin
                step_new    <= 1'b1;
                step_data   <= {11'b0, target_q};
                last_target <= target_q;
            end
        end
    end

endmodule

// File: tb/tb_stepper_cmd_sequencer.sv
// Self-checking bench for stepper_cmd_sequencer against a queue/arithmetic reference model.
module tb_stepper_cmd_sequencer;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned START_WAIT  = 16;
    localparam int unsigned DWELL_SHIFT = 10;

    logic                   CLK100MHZ;
    logic                   CPU_RESETN;
    logic [31:0]            cmd_data;
    logic                   cmd_wr;
    logic                   cmd_full;
    logic [$clog2(DEPTH):0] cmd_count;
    logic [31:0]            step_data;
    logic                   step_new;
    logic                   step_busy;
    logic                   seq_busy;
    logic                   err_ovf;
    logic [20:0]            last_target;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [20:0] model_pos;

    stepper_cmd_sequencer #(
        .DEPTH      (DEPTH),
        .START_WAIT (START_WAIT),
        .DWELL_SHIFT(DWELL_SHIFT)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .cmd_data   (cmd_data),
        .cmd_wr     (cmd_wr),
        .cmd_full   (cmd_full),
        .cmd_count  (cmd_count),
        .step_data  (step_data),
        .step_new   (step_new),
        .step_busy  (step_busy),
        .seq_busy   (seq_busy),
        .err_ovf    (err_ovf),
        .last_target(last_target)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    function automatic logic [20:0] rel_target(input logic [20:0] pos, input logic [20:0] arg);
        int sa;
        int t;
        sa = (arg >= 21'h100000) ? int'(arg) - (1 << 21) : int'(arg);
        t = (int'(pos) + sa) % (1 << 21);
        if (t < 0) t = t + (1 << 21);
        return t[20:0];
    endfunction

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic do_reset();
        cmd_wr     = 1'b0;
        cmd_data   = '0;
        step_busy  = 1'b0;
        CPU_RESETN = 1'b0;
        #13;
        tick();
        CPU_RESETN = 1'b1;
        tick();
        model_pos = '0;
    endtask

    task automatic write_cmd(input logic [1:0] op, input logic [20:0] arg);
        cmd_data = {op, 9'b0, arg};
        cmd_wr   = 1'b1;
        tick();
        cmd_wr   = 1'b0;
    endtask

    task automatic wait_issue(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int c = 0; c <= budget; c++) begin
            if (step_new === 1'b1) begin
                seen   = 1'b1;
                cycles = c;
                break;
            end
            if (c < budget) tick();
        end
    endtask

    task automatic serve_move(input int budget, input int busy_len, output bit seen, output int cycles,
                              output logic [31:0] data, output logic [20:0] lt, output logic new_after);
        wait_issue(budget, seen, cycles);
        data      = step_data;
        lt        = last_target;
        new_after = 1'b0;
        if (seen) begin
            step_busy = 1'b1;
            tick();
            new_after = step_new;
            repeat (busy_len - 1) tick();
            step_busy = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (step_new !== 1'b0) $display("FAIL reset_step_new got=%0h exp=0", step_new); else pass_cnt++;
        total_cnt++; if (step_data !== 32'h0) $display("FAIL reset_step_data got=%0h exp=0", step_data); else pass_cnt++;
        total_cnt++; if (last_target !== 21'h0) $display("FAIL reset_last_target got=%0h exp=0", last_target); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL reset_err_ovf got=%0h exp=0", err_ovf); else pass_cnt++;
        total_cnt++; if (cmd_count !== '0) $display("FAIL reset_cmd_count got=%0d exp=0", cmd_count); else pass_cnt++;
        total_cnt++; if (cmd_full !== 1'b0) $display("FAIL reset_cmd_full got=%0h exp=0", cmd_full); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL reset_seq_busy got=%0h exp=0", seq_busy); else pass_cnt++;
    endtask

    task automatic test_latency();
        write_cmd(2'b00, 21'd100);
        model_pos = 21'd100;
        total_cnt++; if (step_new !== 1'b0) $display("FAIL latency_early1 got=%0h exp=0", step_new); else pass_cnt++;
        tick();
        total_cnt++; if (step_new !== 1'b0) $display("FAIL latency_early2 got=%0h exp=0", step_new); else pass_cnt++;
        tick();
        total_cnt++; if (step_new !== 1'b1) $display("FAIL latency_pulse got=%0h exp=1", step_new); else pass_cnt++;
        total_cnt++; if (step_data !== {11'b0, model_pos}) $display("FAIL latency_data got=%0h exp=%0h", step_data, model_pos); else pass_cnt++;
        total_cnt++; if (last_target !== model_pos) $display("FAIL latency_last got=%0h exp=%0h", last_target, model_pos); else pass_cnt++;
        step_busy = 1'b1;
        tick();
        total_cnt++; if (step_new !== 1'b0) $display("FAIL latency_one_cycle got=%0h exp=0", step_new); else pass_cnt++;
        repeat (5) tick();
        step_busy = 1'b0;
        tick();
        tick();
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL latency_idle got=%0h exp=0", seq_busy); else pass_cnt++;
    endtask

    task automatic test_sequence();
        logic [20:0] args [3];
        logic [1:0]  ops  [3];
        logic [20:0] exp_q[$];
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw;
        ops[0] = 2'b00; args[0] = 21'd50;
        ops[1] = 2'b01; args[1] = 21'd25;
        ops[2] = 2'b01; args[2] = 21'((1 << 21) - 100);
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            model_pos = (ops[i] == 2'b00) ? args[i] : rel_target(model_pos, args[i]);
            exp_q.push_back(model_pos);
            write_cmd(ops[i], args[i]);
        end
        foreach (exp_q[i]) begin
            serve_move(200, 20, seen, cyc, data, lt, nw);
            total_cnt++; if (!seen) $display("FAIL seq_issue%0d got=timeout exp=pulse", i); else pass_cnt++;
            total_cnt++; if (data !== {11'b0, exp_q[i]}) $display("FAIL seq_data%0d got=%0h exp=%0h", i, data, exp_q[i]); else pass_cnt++;
            total_cnt++; if (lt !== exp_q[i]) $display("FAIL seq_last%0d got=%0h exp=%0h", i, lt, exp_q[i]); else pass_cnt++;
            total_cnt++; if (nw !== 1'b0) $display("FAIL seq_pulse_width%0d got=%0h exp=0", i, nw); else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [20:0] exp_q[$];
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw; int extra;
        exp_q = {};
        step_busy = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(21'($urandom));
            write_cmd(2'b00, exp_q[i]);
        end
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL ovf_not_yet got=%0h exp=0", err_ovf); else pass_cnt++;
        total_cnt++; if (cmd_full !== 1'b1) $display("FAIL ovf_full_at_depth got=%0h exp=1", cmd_full); else pass_cnt++;
        write_cmd(2'b00, 21'h0ABCDE);
        total_cnt++; if (err_ovf !== 1'b1) $display("FAIL ovf_sticky_set got=%0h exp=1", err_ovf); else pass_cnt++;
        total_cnt++; if (cmd_count !== (DEPTH)) $display("FAIL ovf_count got=%0d exp=%0d", cmd_count, DEPTH); else pass_cnt++;
        total_cnt++; if (cmd_full !== 1'b1) $display("FAIL ovf_full got=%0h exp=1", cmd_full); else pass_cnt++;
        step_busy = 1'b0;
        foreach (exp_q[i]) begin
            serve_move(200, 3, seen, cyc, data, lt, nw);
            total_cnt++; if (!seen || data !== {11'b0, exp_q[i]}) $display("FAIL ovf_data%0d got=%0h exp=%0h", i, data, exp_q[i]); else pass_cnt++;
        end
        model_pos = exp_q[DEPTH-1];
        extra = 0;
        repeat (40) begin
            tick();
            if (step_new === 1'b1) extra++;
        end
        total_cnt++; if (extra != 0) $display("FAIL ovf_dropped_word got=%0d issues exp=0", extra); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b1) $display("FAIL ovf_still_set got=%0h exp=1", err_ovf); else pass_cnt++;
    endtask

    task automatic test_null_move();
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw;
        logic [20:0] next_t;
        next_t = model_pos ^ 21'h155555;
        write_cmd(2'b00, model_pos);
        write_cmd(2'b00, next_t);
        wait_issue(50, seen, cyc);
        total_cnt++; if (!seen || step_data !== {11'b0, model_pos}) $display("FAIL null_first got=%0h exp=%0h", step_data, model_pos); else pass_cnt++;
        tick();
        serve_move(100, 4, seen, cyc, data, lt, nw);
        cyc = cyc + 1;
        total_cnt++; if (!seen || data !== {11'b0, next_t}) $display("FAIL null_next got=%0h exp=%0h", data, next_t); else pass_cnt++;
        total_cnt++; if (cyc < START_WAIT + 1 || cyc > START_WAIT + 3) $display("FAIL null_gap got=%0d exp=%0d..%0d", cyc, START_WAIT + 1, START_WAIT + 3); else pass_cnt++;
        model_pos = next_t;
    endtask

    task automatic test_dwell();
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw;
        logic [20:0] t;
        int dwell_cycles;
        t = 21'($urandom);
        dwell_cycles = 2 << DWELL_SHIFT;
        write_cmd(2'b10, 21'd2);
        write_cmd(2'b00, t);
        total_cnt++; if (cmd_count !== 1) $display("FAIL dwell_pending got=%0d exp=1", cmd_count); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b1) $display("FAIL dwell_busy got=%0h exp=1", seq_busy); else pass_cnt++;
        serve_move(dwell_cycles + 100, 2, seen, cyc, data, lt, nw);
        total_cnt++; if (!seen || cyc < dwell_cycles || cyc > dwell_cycles + 4) $display("FAIL dwell_time got=%0d exp=%0d..%0d", cyc, dwell_cycles, dwell_cycles + 4); else pass_cnt++;
        total_cnt++; if (data !== {11'b0, t}) $display("FAIL dwell_data got=%0h exp=%0h", data, t); else pass_cnt++;
        model_pos = t;
    endtask

    task automatic test_random();
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw;
        for (int b = 0; b < 4; b++) begin
            int n;
            logic [20:0] exp_q[$];
            exp_q = {};
            n = $urandom_range(1, DEPTH);
            step_busy = 1'b1;
            tick();
            for (int i = 0; i < n; i++) begin
                int k;
                logic [20:0] arg;
                k = $urandom_range(0, 2);
                arg = 21'($urandom);
                if (k == 2) begin
                    write_cmd(2'b10, 21'd0);
                end else begin
                    model_pos = (k == 0) ? arg : rel_target(model_pos, arg);
                    exp_q.push_back(model_pos);
                    write_cmd(k[1:0], arg);
                end
            end
            total_cnt++; if (cmd_count !== n) $display("FAIL rand_count%0d got=%0d exp=%0d", b, cmd_count, n); else pass_cnt++;
            step_busy = 1'b0;
            foreach (exp_q[i]) begin
                serve_move(200, $urandom_range(1, 6), seen, cyc, data, lt, nw);
                total_cnt++; if (!seen || data !== {11'b0, exp_q[i]}) $display("FAIL rand_data%0d_%0d got=%0h exp=%0h", b, i, data, exp_q[i]); else pass_cnt++;
                total_cnt++; if (lt !== exp_q[i]) $display("FAIL rand_last%0d_%0d got=%0h exp=%0h", b, i, lt, exp_q[i]); else pass_cnt++;
            end
            repeat (4) tick();
            total_cnt++; if (seq_busy !== 1'b0) $display("FAIL rand_idle%0d got=%0h exp=0", b, seq_busy); else pass_cnt++;
        end
    endtask

    task automatic test_op11();
        bit seen; int cyc; logic [31:0] data; logic [20:0] lt; logic nw;
        logic [20:0] t;
        t = 21'($urandom);
`ifdef STEPPER_SEQ_FLUSH_EN
        begin
            int extra;
            do_reset();
            step_busy = 1'b1;
            tick();
            for (int i = 0; i < DEPTH; i++) write_cmd(2'b00, 21'(i + 7));
            write_cmd(2'b11, 21'd0);
            total_cnt++; if (cmd_count !== 0) $display("FAIL flush_count got=%0d exp=0", cmd_count); else pass_cnt++;
            total_cnt++; if (err_ovf !== 1'b0) $display("FAIL flush_no_ovf got=%0h exp=0", err_ovf); else pass_cnt++;
            step_busy = 1'b0;
            extra = 0;
            repeat (40) begin
                tick();
                if (step_new === 1'b1) extra++;
            end
            total_cnt++; if (extra != 0) $display("FAIL flush_quiet got=%0d issues exp=0", extra); else pass_cnt++;
            write_cmd(2'b10, 21'd100);
            repeat (5) tick();
            write_cmd(2'b11, 21'd0);
            write_cmd(2'b00, t);
            serve_move(20, 2, seen, cyc, data, lt, nw);
            total_cnt++; if (!seen || data !== {11'b0, t}) $display("FAIL flush_dwell_abort got=%0h exp=%0h", data, t); else pass_cnt++;
            model_pos = t;
        end
`else
        step_busy = 1'b1;
        tick();
        write_cmd(2'b11, 21'h1FFFFF);
        write_cmd(2'b00, t);
        total_cnt++; if (cmd_count !== 2) $display("FAIL op11_queued got=%0d exp=2", cmd_count); else pass_cnt++;
        step_busy = 1'b0;
        serve_move(50, 2, seen, cyc, data, lt, nw);
        total_cnt++; if (!seen || data !== {11'b0, t}) $display("FAIL op11_next got=%0h exp=%0h", data, t); else pass_cnt++;
        total_cnt++; if (cyc != 3) $display("FAIL op11_discard_time got=%0d exp=3", cyc); else pass_cnt++;
        model_pos = t;
`endif
    endtask

    task automatic test_reset_midmove();
        bit seen; int cyc; int extra;
        write_cmd(2'b00, model_pos ^ 21'h0F0F0F);
        wait_issue(50, seen, cyc);
        step_busy = 1'b1;
        tick();
        write_cmd(2'b00, 21'd1);
        write_cmd(2'b01, 21'd2);
        #3;
        CPU_RESETN = 1'b0;
        #1;
        total_cnt++; if (cmd_count !== 0) $display("FAIL midreset_count got=%0d exp=0", cmd_count); else pass_cnt++;
        total_cnt++; if (last_target !== 21'h0) $display("FAIL midreset_last got=%0h exp=0", last_target); else pass_cnt++;
        total_cnt++; if (seq_busy !== 1'b0) $display("FAIL midreset_seq_busy got=%0h exp=0", seq_busy); else pass_cnt++;
        tick();
        CPU_RESETN = 1'b1;
        model_pos  = '0;
        repeat (3) tick();
        step_busy = 1'b0;
        extra = 0;
        repeat (30) begin
            tick();
            if (step_new === 1'b1) extra++;
        end
        total_cnt++; if (extra != 0) $display("FAIL midreset_quiet got=%0d issues exp=0", extra); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sequence();
        test_overflow();
        test_null_move();
        test_dwell();
        test_random();
        test_op11();
        test_reset_midmove();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
